// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS control FSM: fetch/decode/exec/mem/wb sequencing, memory
// handshake with wait timeout, retired-instruction counter and sticky trap.
module mips_multicycle_ctrl #(
   parameter int MEM_TIMEOUT = 255,
   parameter int CNT_W       = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [5:0]       opcode,
   input  logic [5:0]       funct,
   input  logic             branch_taken,
   input  logic             mem_ready,
   output logic             mem_read,
   output logic             mem_write,
   output logic             mem_addr_sel,
   output logic [1:0]       mem_size,
   output logic             ir_write,
   output logic             pc_write,
   output logic             pc_src,
   output logic             alu_latch,
   output logic             reg_write,
   output logic             reg_dst,
   output logic             mem_to_reg,
   output logic             trap,
   output logic [1:0]       trap_cause,
   output logic [CNT_W-1:0] retired_count,
   output logic [2:0]       state
);

   localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

   typedef enum logic [2:0] {
      S_BOOT = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2, S_EXEC = 3'd3,
      S_MEM  = 3'd4, S_WB    = 3'd5, S_TRAP   = 3'd6
   } state_t;

   typedef enum logic [2:0] {C_R, C_IMM, C_BR, C_ST, C_LD, C_ILL} cls_t;

   state_t            st, st_nxt;
   cls_t              cls, dec_cls;
   logic [1:0]        size_q, dec_size;
   logic [WAIT_W-1:0] wait_cnt;
   logic              mem_wait, timeout, retire;

   assign state = st;

   always_comb begin
      dec_cls = C_ILL;
      case (opcode)
         6'b000000: if (funct inside {6'b100000, 6'b100010, 6'b100100,
                                      6'b100101, 6'b100111, 6'b101010})
                       dec_cls = C_R;
         6'b001000, 6'b001100, 6'b001101, 6'b001010: dec_cls = C_IMM;
         6'b000100, 6'b000101, 6'b000001:            dec_cls = C_BR;
         6'b101000, 6'b101001, 6'b101011:            dec_cls = C_ST;
         6'b100000, 6'b100001, 6'b100011:            dec_cls = C_LD;
         default: ;
      endcase
      // b/h/w forms of loads and stores differ only in opcode[1:0]
      case (opcode[1:0])
         2'b00:   dec_size = 2'b00;
         2'b01:   dec_size = 2'b01;
         default: dec_size = 2'b10;
      endcase
   end

   assign mem_wait = ((st == S_FETCH) || (st == S_MEM)) && !mem_ready;
   assign timeout  = mem_wait && (wait_cnt == WAIT_W'(MEM_TIMEOUT - 1));
   assign retire   = ((st == S_EXEC) && (cls == C_BR)) ||
                     ((st == S_MEM) && mem_ready && (cls == C_ST)) ||
                     (st == S_WB);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) st <= S_BOOT;
      else       st <= st_nxt;
   end

   always_comb begin
      st_nxt = st;
      case (st)
         S_BOOT:   st_nxt = S_FETCH;
         S_FETCH:  if (mem_ready)   st_nxt = S_DECODE;
                   else if (timeout) st_nxt = S_TRAP;
         S_DECODE: st_nxt = (dec_cls == C_ILL) ? S_TRAP : S_EXEC;
         S_EXEC:   case (cls)
                      C_BR:       st_nxt = S_FETCH;
                      C_ST, C_LD: st_nxt = S_MEM;
                      default:    st_nxt = S_WB;
                   endcase
         S_MEM:    if (mem_ready)    st_nxt = (cls == C_LD) ? S_WB : S_FETCH;
                   else if (timeout) st_nxt = S_TRAP;
         S_WB:     st_nxt = S_FETCH;
         S_TRAP:   st_nxt = S_TRAP;
         default:  st_nxt = S_BOOT;
      endcase
   end

   // Instruction class, access size, wait counter, retire count, trap cause
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cls           <= C_ILL;
         size_q        <= 2'b00;
         wait_cnt      <= '0;
         retired_count <= '0;
         trap_cause    <= 2'b00;
      end else begin
         if (st == S_DECODE) begin
            cls    <= dec_cls;
            size_q <= dec_size;
         end
         wait_cnt <= mem_wait ? wait_cnt + WAIT_W'(1) : '0;
         if (retire) retired_count <= retired_count + CNT_W'(1);
         if ((st == S_DECODE) && (dec_cls == C_ILL)) trap_cause <= 2'b01;
         else if (timeout)                           trap_cause <= 2'b10;
      end
   end

   always_comb begin
      mem_read     = 1'b0;
      mem_write    = 1'b0;
      mem_addr_sel = 1'b0;
      mem_size     = 2'b00;
      ir_write     = 1'b0;
      pc_write     = 1'b0;
      pc_src       = 1'b0;
      alu_latch    = 1'b0;
      reg_write    = 1'b0;
      reg_dst      = 1'b0;
      mem_to_reg   = 1'b0;
      trap         = 1'b0;
      case (st)
         S_FETCH: begin
            mem_read = 1'b1;
            mem_size = 2'b10;
            ir_write = mem_ready;
            pc_write = mem_ready;
         end
         S_EXEC: begin
            alu_latch = 1'b1;
            if (cls == C_BR) begin
               pc_src   = 1'b1;
               pc_write = branch_taken;
            end
         end
         S_MEM: begin
            mem_addr_sel = 1'b1;
            mem_read     = (cls == C_LD);
            mem_write    = (cls == C_ST);
            mem_size     = size_q;
         end
         S_WB: begin
            reg_write  = 1'b1;
            reg_dst    = (cls == C_R);
            mem_to_reg = (cls == C_LD);
         end
         S_TRAP:  trap = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed scoreboard bench for mips_multicycle_ctrl: per-cycle expected state,
// control outputs and retire count are queued with the stimulus, then compared.
module tb_mips_multicycle_ctrl;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [5:0] opcode = '0, funct = '0;
   logic       branch_taken = 1'b0, mem_ready = 1'b0;
   logic       mem_read, mem_write, mem_addr_sel, ir_write, pc_write, pc_src;
   logic       alu_latch, reg_write, reg_dst, mem_to_reg, trap;
   logic [1:0] mem_size, trap_cause;
   logic [2:0] retired_count, state;
   logic [14:0] obs_o;

   always #5 clk = ~clk;

   mips_multicycle_ctrl #(.MEM_TIMEOUT(4), .CNT_W(3)) dut (
      .clk(clk), .reset(reset), .opcode(opcode), .funct(funct),
      .branch_taken(branch_taken), .mem_ready(mem_ready),
      .mem_read(mem_read), .mem_write(mem_write), .mem_addr_sel(mem_addr_sel),
      .mem_size(mem_size), .ir_write(ir_write), .pc_write(pc_write),
      .pc_src(pc_src), .alu_latch(alu_latch), .reg_write(reg_write),
      .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .trap(trap),
      .trap_cause(trap_cause), .retired_count(retired_count), .state(state)
   );

   assign obs_o = {mem_read, mem_write, mem_addr_sel, mem_size, ir_write, pc_write,
                   pc_src, alu_latch, reg_write, reg_dst, mem_to_reg, trap, trap_cause};

   typedef struct {
      string       tag;
      logic [5:0]  op, fn;
      logic        rdy, bt;
      logic [2:0]  st;
      logic [14:0] o;
      logic [2:0]  rc;
   } rec_t;

   rec_t       q[$];
   int         checks = 0, errors = 0;
   logic [2:0] m_rc = '0;
   logic [5:0] cur_op = '0, cur_fn = '0;
   string      cur_tag = "init";

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [14:0] ov(input logic rd, wr, asel, input logic [1:0] sz,
                                      input logic irw, pcw, pcs, alu, rw, rdst, m2r, tr,
                                      input logic [1:0] cause);
      return {rd, wr, asel, sz, irw, pcw, pcs, alu, rw, rdst, m2r, tr, cause};
   endfunction

   task automatic push(input logic [2:0] st, input logic [14:0] o, input logic rdy, input logic bt);
      rec_t r;
      r.tag = cur_tag;
      r.op  = (st <= 3'd1) ? 6'h3f : cur_op;  // IR contents are not meaningful before DECODE
      r.fn  = (st <= 3'd1) ? 6'h3f : cur_fn;
      r.rdy = rdy; r.bt = bt; r.st = st; r.o = o; r.rc = m_rc;
      q.push_back(r);
   endtask

   task automatic instr(input string tag, input logic [5:0] op, input logic [5:0] fn);
      cur_tag = tag; cur_op = op; cur_fn = fn;
   endtask

   task automatic p_boot();
      push(3'd0, '0, 1'b0, 1'b0);
   endtask
   task automatic p_fetch(input int waits);
      for (int w = 0; w < waits; w++) push(3'd1, ov(1,0,0,2'b10,0,0,0,0,0,0,0,0,2'b00), 1'b0, 1'b1);
      push(3'd1, ov(1,0,0,2'b10,1,1,0,0,0,0,0,0,2'b00), 1'b1, 1'b0);
   endtask
   task automatic p_dec();
      push(3'd2, '0, 1'b1, 1'b1);
   endtask
   task automatic p_exec(input logic br, input logic bt);
      push(3'd3, ov(0,0,0,2'b00,0,br & bt,br,1,0,0,0,0,2'b00), 1'b1, bt);
   endtask
   task automatic p_mem_stall(input logic ld, input logic [1:0] sz, input int n);
      for (int w = 0; w < n; w++) push(3'd4, ov(ld,!ld,1,sz,0,0,0,0,0,0,0,0,2'b00), 1'b0, 1'b1);
   endtask
   task automatic p_mem(input logic ld, input logic [1:0] sz, input int waits);
      p_mem_stall(ld, sz, waits);
      push(3'd4, ov(ld,!ld,1,sz,0,0,0,0,0,0,0,0,2'b00), 1'b1, 1'b0);
   endtask
   task automatic p_wb(input logic r, input logic ld);
      push(3'd5, ov(0,0,0,2'b00,0,0,0,0,1,r,ld,0,2'b00), 1'b1, 1'b1);
   endtask
   task automatic p_trap(input logic [1:0] cause, input int n);
      for (int i = 0; i < n; i++) push(3'd6, ov(0,0,0,2'b00,0,0,0,0,0,0,0,1,cause), i[0], 1'b1);
   endtask
   task automatic retire();
      m_rc = m_rc + 3'd1;
   endtask

   task automatic run();
      rec_t r;
      while (q.size() > 0) begin
         r = q.pop_front();
         @(negedge clk);
         opcode = r.op; funct = r.fn; mem_ready = r.rdy; branch_taken = r.bt;
         #1;
         chk({r.tag, ":state"}, 32'(state), 32'(r.st));
         chk({r.tag, ":ctrl"}, 32'(obs_o), 32'(r.o));
         chk({r.tag, ":retired"}, 32'(retired_count), 32'(r.rc));
      end
   endtask

   // Asserts reset mid-cycle and checks the asynchronous drop to BOOT values.
   task automatic do_reset(input string tag);
      #1 reset = 1'b1;
      #1;
      chk({tag, ":rst_state"}, 32'(state), 32'd0);
      chk({tag, ":rst_ctrl"}, 32'(obs_o), 32'd0);
      chk({tag, ":rst_retired"}, 32'(retired_count), 32'd0);
      m_rc = '0;
      @(posedge clk);
      #2 reset = 1'b0;
   endtask

   initial begin
      do_reset("por");
      p_boot();
      instr("add", 6'b000000, 6'b100000);
      p_fetch(0); p_dec(); p_exec(0, 0); p_wb(1, 0); retire();
      instr("lw", 6'b100011, 6'b000000);
      p_fetch(0); p_dec(); p_exec(0, 1); p_mem(1, 2'b10, 3); p_wb(0, 1); retire();
      instr("beq", 6'b000100, 6'b000000);
      p_fetch(0); p_dec(); p_exec(1, 1); retire();
      instr("bne", 6'b000101, 6'b000000);
      p_fetch(0); p_dec(); p_exec(1, 0); retire();
      instr("sb_lastwait", 6'b101000, 6'b000000);
      p_fetch(3); p_dec(); p_exec(0, 0); p_mem(0, 2'b00, 3); retire();
      instr("lh", 6'b100001, 6'b000000);
      p_fetch(1); p_dec(); p_exec(0, 0); p_mem(1, 2'b01, 0); p_wb(0, 1); retire();
      instr("addi", 6'b001000, 6'b000000);
      p_fetch(0); p_dec(); p_exec(0, 1); p_wb(0, 0); retire();
      instr("bltz_wrap", 6'b000001, 6'b000000);
      p_fetch(0); p_dec(); p_exec(1, 1); retire();
      instr("sw", 6'b101011, 6'b000000);
      p_fetch(0); p_dec(); p_exec(0, 0); p_mem(0, 2'b10, 0); retire();
      instr("or", 6'b000000, 6'b100101);
      p_fetch(0); p_dec(); p_exec(0, 0); p_wb(1, 0); retire();
      instr("ill_funct", 6'b000000, 6'b000011);
      p_fetch(0); p_dec(); p_trap(2'b01, 21);
      run();
      do_reset("after_ill");

      p_boot();
      instr("sb_timeout", 6'b101000, 6'b000000);
      p_fetch(0); p_dec(); p_exec(0, 0); p_mem_stall(0, 2'b00, 4); p_trap(2'b10, 3);
      run();
      do_reset("after_tmo");

      p_boot();
      instr("add2", 6'b000000, 6'b100010);
      p_fetch(0); p_dec(); p_exec(0, 0); p_wb(1, 0); retire();
      instr("lw_abort", 6'b100011, 6'b000000);
      p_fetch(0); p_dec(); p_exec(0, 0); p_mem_stall(1, 2'b10, 2);
      run();
      do_reset("mid_mem");

      p_boot();
      instr("ill_op", 6'b111111, 6'b000000);
      p_fetch(0); p_dec(); p_trap(2'b01, 2);
      run();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mips_multicycle_ctrl.md
# mips_multicycle_ctrl

Multi-cycle control FSM for the MIPS_32 core. It steps each instruction through fetch, decode, execute, memory and writeback, reusing the single combinational ALU and one memory port. It decodes opcode/funct, consumes the ALU branch flag, handshakes with memory through a ready signal, counts retired instructions and traps on illegal encodings or memory timeout.

## Interface
- MEM_TIMEOUT, 255: maximum consecutive cycles spent waiting for mem_ready before trapping.
- CNT_W, 32: width of retired_count.
- clk  in  1  sole clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high; forces BOOT immediately.
- opcode  in  6  IR[31:26]; valid from DECODE onward.
- funct  in  6  IR[5:0]; valid from DECODE onward.
- branch_taken  in  1  ALU Branch flag; sampled in EXEC only.
- mem_ready  in  1  memory completes the current access this cycle.
- mem_read, mem_write  out  1  memory strobes, held until mem_ready.
- mem_addr_sel  out  1  0 = PC, 1 = ALU result register.
- mem_size  out  2  00 byte, 01 half, 10 word.
- ir_write, pc_write  out  1  IR load / PC load enables.
- pc_src  out  1  0 = PC+4, 1 = branch target.
- alu_latch  out  1  capture ALU writeData into ALU result register.
- reg_write, reg_dst, mem_to_reg  out  1  regfile write, 1 = rd (else rt), 1 = memory data.
- trap  out  1  sticky trap flag.
- trap_cause  out  2  00 none, 01 illegal instruction, 10 memory timeout.
- retired_count  out  CNT_W  retired instructions, wraps modulo 2^CNT_W.
- state  out  3  BOOT 0, FETCH 1, DECODE 2, EXEC 3, MEM 4, WB 5, TRAP 6.

## Operation
- Reset values: state = BOOT, retired_count = 0, trap = 0, trap_cause = 00, wait counter = 0. All strobes/enables are 0 in BOOT.
- All control outputs are Moore outputs decoded from state plus the instruction-class register. The only Mealy terms are pc_write and ir_write, which are qualified by mem_ready or branch_taken.
- BOOT: all outputs are 0. Goes to FETCH on the next edge.
- FETCH: mem_read = 1, mem_addr_sel = 0, mem_size = 10. When mem_ready = 1: ir_write = 1, pc_write = 1, pc_src = 0, then go to DECODE.
- DECODE: classify the instruction and latch the class. Legal encodings:
  - R-type: opcode 000000 with funct 100000, 100010, 100100, 100101, 100111 or 101010.
  - Immediate ALU: 001000, 001100, 001101, 001010.
  - Branch: 000100, 000101, 000001.
  - Store: 101000, 101001, 101011.
  - Load: 100000, 100001, 100011.
  - Anything else goes to TRAP with cause 01; otherwise go to EXEC.
- EXEC: alu_latch = 1.
  - Branch class: pc_write = branch_taken, pc_src = 1; retire; go to FETCH.
  - Load/store: go to MEM.
  - R-type/immediate: go to WB.
- MEM: mem_addr_sel = 1. mem_read = 1 for loads, mem_write = 1 for stores. mem_size: b-forms 00, h-forms 01, w-forms 10.
  - On mem_ready, a store retires and goes to FETCH; a load goes to WB.
- WB: reg_write = 1. reg_dst = 1 only for R-type; mem_to_reg = 1 only for loads. Retire; go to FETCH.
- TRAP: all strobes/enables are 0, trap = 1, trap_cause is held. Only reset exits TRAP.
- Wait counter:
  - Clears on entry to FETCH or MEM.
  - Increments each FETCH/MEM cycle with mem_ready = 0.
  - When it reaches MEM_TIMEOUT with mem_ready still 0, go to TRAP with cause 10.
  - If mem_ready arrives on the same cycle the limit is reached, mem_ready wins and there is no trap.
- Retire: retired_count increments by 1 on the edge leaving EXEC (branch), MEM (store) or WB. It wraps from all-ones to 0.

## Timing
- Latency with zero-wait memory (mem_ready = 1 on the first FETCH/MEM cycle):
  - Branch: 3 cycles.
  - R-type, immediate and store: 4 cycles.
  - Load: 5 cycles.
- Each memory wait cycle adds 1 cycle.
- mem_read/mem_write stay asserted and stable until the cycle mem_ready is sampled high, and deassert on the following edge.
- branch_taken is ignored outside EXEC, and in EXEC for non-branch classes.
- Reset asserted mid-access: outputs drop to BOOT values asynchronously, with no retire and no PC/IR write. The in-flight memory access is abandoned.
- After reset deasserts, the first FETCH strobe appears 1 cycle later (BOOT lasts exactly one cycle).

## Test plan
- add (opcode 000000, funct 100000) with mem_ready tied 1 → state sequence 0,1,2,3,5,1. reg_write = 1 and reg_dst = 1 for exactly one cycle; retired_count 0→1.
- lw (100011), FETCH ready immediately, MEM ready after 3 wait cycles → mem_read held 4 cycles in MEM with mem_addr_sel = 1, mem_size = 10. Then WB with mem_to_reg = 1; 8 cycles total.
- beq (000100) with branch_taken = 1, then bne with branch_taken = 0 → first asserts pc_write = 1, pc_src = 1 in EXEC; second keeps pc_write = 0. Each takes 3 cycles, and retired_count increments by 2 in total.
- opcode 000000 with funct 000011 → TRAP at cycle 3, trap_cause = 01. trap stays high and retired_count is unchanged for 20 further cycles; reset returns to BOOT.
- MEM_TIMEOUT = 4, sb (101000) with mem_ready held 0 → mem_write = 1 and mem_size = 00 for 4 MEM cycles, then TRAP with cause 10. Repeat with mem_ready = 1 on the 4th wait cycle → no trap, store retires.
- reset asserted in MEM during a load wait → all outputs 0 immediately. State is BOOT then FETCH, and retired_count is reset to 0.
